// File: rtl/spi_master_shifter.sv
// SPI mode-0 master shift engine (MSB first), SCLK divided from clk; SPI_LOOPBACK_EN feeds MOSI back as the shift input.
// Latency: DONE pulses (2*DATA_W+2)*CLK_DIV+1 cycles after START is accepted.
// Backpressure: START is accepted only in IDLE; START in any other state is dropped, never queued.
module spi_master_shifter #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_FIN
    } state_t;

    state_t            state, state_nxt;
    logic [DIV_W-1:0]  div_cnt, div_nxt;
    logic [BIT_W-1:0]  bit_cnt, bit_nxt;
    logic [DATA_W-1:0] tx_sr, tx_sr_nxt;
    logic [DATA_W-1:0] rx_sr, rx_sr_nxt;
    logic [DATA_W-1:0] rx_data_nxt;
    logic              busy_nxt, done_nxt, sclk_nxt, mosi_nxt, cs_n_nxt;
    logic              shift_in;
    logic              div_wrap;

`ifdef SPI_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = miso;
    // The registered MOSI bit is stable across the rising SCLK edge, so it is the bit being sent.
    assign shift_in    = mosi;
`else
    assign shift_in    = miso;
`endif

    assign div_wrap = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_data <= '0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            cs_n    <= 1'b1;
        end else begin
            state   <= state_nxt;
            div_cnt <= div_nxt;
            bit_cnt <= bit_nxt;
            tx_sr   <= tx_sr_nxt;
            rx_sr   <= rx_sr_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            rx_data <= rx_data_nxt;
            sclk    <= sclk_nxt;
            mosi    <= mosi_nxt;
            cs_n    <= cs_n_nxt;
        end
    end

    // Next-state logic computes the value every output register takes on the coming edge.
    always_comb begin
        state_nxt   = state;
        div_nxt     = div_cnt;
        bit_nxt     = bit_cnt;
        tx_sr_nxt   = tx_sr;
        rx_sr_nxt   = rx_sr;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        rx_data_nxt = rx_data;
        sclk_nxt    = sclk;
        mosi_nxt    = mosi;
        cs_n_nxt    = cs_n;

        case (state)
            S_IDLE: begin
                busy_nxt = 1'b0;
                cs_n_nxt = 1'b1;
                sclk_nxt = 1'b0;
                if (start) begin
                    state_nxt = S_SETUP;
                    tx_sr_nxt = tx_data;
                    rx_sr_nxt = '0;
                    mosi_nxt  = tx_data[DATA_W-1];
                    busy_nxt  = 1'b1;
                    cs_n_nxt  = 1'b0;
                    div_nxt   = '0;
                    bit_nxt   = '0;
                end
            end

            S_SETUP: begin
                if (div_wrap) begin
                    div_nxt   = '0;
                    state_nxt = S_SHIFT;
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end

            S_SHIFT: begin
                if (div_wrap) begin
                    div_nxt  = '0;
                    sclk_nxt = ~sclk;
                    if (!sclk) begin
                        rx_sr_nxt = {rx_sr[DATA_W-2:0], shift_in};
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                        // On the final falling edge MOSI keeps the last bit sent.
                        if (bit_cnt == BIT_LAST) begin
                            state_nxt = S_HOLD;
                        end else begin
                            tx_sr_nxt = tx_sr << 1;
                            mosi_nxt  = tx_sr[DATA_W-2];
                        end
                    end
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end

            S_HOLD: begin
                if (div_wrap) begin
                    div_nxt     = '0;
                    state_nxt   = S_FIN;
                    cs_n_nxt    = 1'b1;
                    done_nxt    = 1'b1;
                    rx_data_nxt = rx_sr;
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end

            S_FIN: begin
                state_nxt = S_IDLE;
                busy_nxt  = 1'b0;
            end

            default: begin
                state_nxt = S_IDLE;
                busy_nxt  = 1'b0;
                cs_n_nxt  = 1'b1;
                sclk_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_master_shifter.sv
// Bench for spi_master_shifter: default (8,4) instance with a mode-0 slave model, plus a (16,1) instance.
module tb_spi_master_shifter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    logic        start0 = 1'b0, busy0, done0, sclk0, mosi0, cs0;
    logic        miso0 = 1'b0;
    logic [7:0]  tx0 = 8'h00, rx0;
    logic        start1 = 1'b0, busy1, done1, sclk1, mosi1, cs1;
    logic        miso1 = 1'b1;
    logic [15:0] tx1 = 16'h0000, rx1;

    spi_master_shifter u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .tx_data(tx0), .busy(busy0), .done(done0),
        .rx_data(rx0), .sclk(sclk0), .mosi(mosi0), .miso(miso0), .cs_n(cs0)
    );

    spi_master_shifter #(.DATA_W(16), .CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .tx_data(tx1), .busy(busy1), .done(done1),
        .rx_data(rx1), .sclk(sclk1), .mosi(mosi1), .miso(miso1), .cs_n(cs1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int model_latency(input int w, input int d);
        return (2 * w + 2) * d + 1;
    endfunction

    function automatic logic [15:0] model_rx(input logic [15:0] sent, input logic [15:0] slave_word);
`ifdef SPI_LOOPBACK_EN
        return sent;
`else
        return slave_word;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Transfer records reconstructed from the pins, plus a mode-0 slave for instance 0.
    logic [7:0]  slave0 = 8'h00;
    int          fcnt0 = 0, np0 = 0;
    logic [7:0]  cap0 = 8'h00;
    logic        sclk_p0 = 1'b0, cs_p0 = 1'b1;
    int          done_q0[$], np_q0[$], rise_q0[$], fall_q0[$];
    logic [7:0]  cap_q0[$], rx_q0[$];

    always @(negedge clk) begin
        if (cs0 === 1'b1 && !cs_p0) rise_q0.push_back(cyc);
        if (cs0 === 1'b0 && cs_p0) begin
            fall_q0.push_back(cyc);
            cap0 = 8'h00;
            np0  = 0;
        end
        if (sclk0 === 1'b1 && !sclk_p0) begin
            cap0 = {cap0[6:0], mosi0};
            np0++;
        end
        if (sclk0 === 1'b0 && sclk_p0) fcnt0++;
        if (cs0 !== 1'b0) fcnt0 = 0;
        if (done0 === 1'b1) begin
            done_q0.push_back(cyc);
            cap_q0.push_back(cap0);
            np_q0.push_back(np0);
            rx_q0.push_back(rx0);
        end
        sclk_p0 = (sclk0 === 1'b1);
        cs_p0   = (cs0 !== 1'b0);
        miso0   = (fcnt0 < 8) ? slave0[7 - fcnt0] : 1'b0;
    end

    int          np1 = 0, hi1 = 0;
    logic [15:0] cap1 = 16'h0000;
    logic        sclk_p1 = 1'b0, cs_p1 = 1'b1;
    int          done_q1[$], np_q1[$], hi_q1[$];
    logic [15:0] cap_q1[$], rx_q1[$];

    always @(negedge clk) begin
        if (cs1 === 1'b0 && cs_p1) begin
            cap1 = 16'h0000;
            np1  = 0;
            hi1  = 0;
        end
        if (sclk1 === 1'b1) hi1++;
        if (sclk1 === 1'b1 && !sclk_p1) begin
            cap1 = {cap1[14:0], mosi1};
            np1++;
        end
        if (done1 === 1'b1) begin
            done_q1.push_back(cyc);
            cap_q1.push_back(cap1);
            np_q1.push_back(np1);
            hi_q1.push_back(hi1);
            rx_q1.push_back(rx1);
        end
        sclk_p1 = (sclk1 === 1'b1);
        cs_p1   = (cs1 !== 1'b0);
    end

    task automatic clear0();
        done_q0.delete(); np_q0.delete(); rise_q0.delete(); fall_q0.delete();
        cap_q0.delete(); rx_q0.delete();
    endtask

    task automatic wait_done0(input int n, input int budget, input string tag);
        int k = 0;
        while (done_q0.size() < n && k < budget) begin
            tick();
            k++;
        end
        check({tag, "_ndone"}, done_q0.size(), n);
    endtask

    task automatic xfer0(input logic [7:0] t, input logic [7:0] s, input string tag);
        int a;
        clear0();
        slave0 = s;
        tx0    = t;
        start0 = 1'b1;
        a      = cyc;
        tick();
        start0 = 1'b0;
        tx0    = ~t;
        wait_done0(1, 200, tag);
        if (done_q0.size() > 0) begin
            check({tag, "_latency"}, done_q0[0] - a, model_latency(8, 4));
            check({tag, "_rx"}, rx_q0[0], model_rx({8'h00, t}, {8'h00, s}));
            check({tag, "_mosi"}, cap_q0[0], t);
            check({tag, "_pulses"}, np_q0[0], 8);
        end
        tick();
        check({tag, "_busy_after"}, {busy0, done0, cs0}, 3'b001);
    endtask

    task automatic xfer1(input logic [15:0] t, input string tag);
        int a;
        int k = 0;
        done_q1.delete(); np_q1.delete(); hi_q1.delete(); cap_q1.delete(); rx_q1.delete();
        tx1    = t;
        start1 = 1'b1;
        a      = cyc;
        tick();
        start1 = 1'b0;
        while (done_q1.size() < 1 && k < 100) begin
            tick();
            k++;
        end
        check({tag, "_ndone"}, done_q1.size(), 1);
        if (done_q1.size() > 0) begin
            check({tag, "_latency"}, done_q1[0] - a, model_latency(16, 1));
            check({tag, "_rx"}, rx_q1[0], model_rx(t, 16'hFFFF));
            check({tag, "_mosi"}, cap_q1[0], t);
            check({tag, "_pulses"}, np_q1[0], 16);
            check({tag, "_hi_cycles"}, hi_q1[0], 16);
        end
        tick();
    endtask

    initial begin
        int          bad;
        int          a;
        logic [7:0]  t1, t2;

        rst = 1'b1;
        repeat (2) tick();
        check("rst_outputs0", {busy0, done0, cs0, sclk0, mosi0}, 5'b00100);
        check("rst_rx0", rx0, 8'h00);
        check("rst_outputs1", {busy1, done1, cs1, sclk1, rx1}, {4'b0010, 16'h0000});
        rst = 1'b0;
        bad = 0;
        repeat (20) begin
            tick();
            if (busy0 !== 1'b0 || done0 !== 1'b0 || cs0 !== 1'b1 || sclk0 !== 1'b0 || rx0 !== 8'h00) bad++;
        end
        check("idle_stable", bad, 0);

        xfer0(8'hA5, 8'h3C, "a5_3c");
        for (int i = 0; i < 4; i++) begin
            xfer0(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "rand0");
            repeat ($urandom_range(0, 3)) tick();
        end

        // START held high across two transfers; TX_DATA changed mid-transfer.
        clear0();
        t1     = 8'($urandom_range(0, 255));
        t2     = ~t1;
        slave0 = 8'hC3;
        tx0    = t1;
        start0 = 1'b1;
        a      = cyc;
        repeat (10) tick();
        tx0 = t2;
        wait_done0(1, 200, "held1");
        tick();
        tick();
        start0 = 1'b0;
        wait_done0(2, 200, "held2");
        repeat (100) tick();
        check("held_one_per_start", done_q0.size(), 2);
        if (done_q0.size() >= 2 && rise_q0.size() >= 1 && fall_q0.size() >= 2) begin
            check("held_latency", done_q0[0] - a, model_latency(8, 4));
            check("held_spacing", done_q0[1] - done_q0[0], model_latency(8, 4) + 1);
            check("held_tx_first", cap_q0[0], t1);
            check("held_tx_second", cap_q0[1], t2);
            check("held_cs_gap", fall_q0[1] - rise_q0[0], 2);
        end

        // Reset in cycle 30 of a transfer.
        clear0();
        tx0    = 8'($urandom_range(0, 255));
        start0 = 1'b1;
        a      = cyc;
        tick();
        start0 = 1'b0;
        while (cyc < a + 30) tick();
        check("pre_abort_cs", cs0, 1'b0);
        rst = 1'b1;
        tick();
        check("abort_outputs", {cs0, sclk0, busy0, done0}, 4'b1000);
        check("abort_rx", rx0, 8'h00);
        rst = 1'b0;
        repeat (100) tick();
        check("abort_no_done", done_q0.size(), 0);

        xfer0(8'h5A, 8'h00, "x5a");

        xfer1(16'h8001, "w16");
        for (int i = 0; i < 2; i++) xfer1(16'($urandom_range(0, 65535)), "rand1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
